m2_fifo_ctrl: RTL and testbench
===============================

Name: m2_fifo_ctrl

Overview:
- Per-lane FIFO pointer controller sitting directly upstream of the m2 forward buffer.
- Turns per-lane push/pop requests into m2 write address, read address and write-enable, so that each of the Tn m2 units acts as a NUM_WORDS-deep FIFO.
- Tracks occupancy and reports full/empty/count per lane, plus sticky overflow/underflow error flags.
- Drives the read address so that m2's registered read address always points at the current head word; the m2 output is the FIFO head whenever the lane is non-empty.

Parameters:
- Tn, 16, number of lanes (one per m2 unit).
- ADDR, 2, address width per lane.
- NUM_WORDS, 4, depth per lane; must equal 2**ADDR.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- i_clr  input  1  synchronous flush of all lanes; same effect as rst on pointers and counts; does not clear error flags.
- i_push  input  Tn  per-lane push request; the write data goes straight to m2 i_data.
- i_pop  input  Tn  per-lane pop request; consumes the current head.
- o_wr_addr  output  ADDR*Tn  per-lane write address to m2; lane i occupies bits [(i+1)*ADDR-1 : i*ADDR].
- o_rd_addr  output  ADDR*Tn  per-lane read address to m2; same packing as o_wr_addr.
- o_wen  output  Tn  per-lane write enable to m2.
- o_empty  output  Tn  lane holds 0 words.
- o_full  output  Tn  lane holds NUM_WORDS words.
- o_count  output  (ADDR+1)*Tn  per-lane occupancy, 0..NUM_WORDS.
- o_err  output  2*Tn  per lane: bit 2i is sticky overflow, bit 2i+1 is sticky underflow.

Behaviour:
- Per-lane state: wr_ptr (ADDR bits), rd_ptr (ADDR bits), count (ADDR+1 bits), err (2 bits). Lanes are fully independent.
- Pointers wrap naturally modulo NUM_WORDS.
- pop_ok = i_pop & (count != 0).
- push_ok = i_push & ((count != NUM_WORDS) | pop_ok). Push while full is accepted only when a pop is accepted in the same cycle.
- o_wen = push_ok & ~rst & ~i_clr (combinational).
- o_wr_addr = wr_ptr (combinational).
- o_rd_addr = rd_ptr + pop_ok, mod NUM_WORDS (combinational). Since m2 registers the read address, after each edge m2 reads mem[rd_ptr], i.e. the head.
- Latency:
  - A word pushed at edge k is visible on m2 o_data after edge k when the lane was empty; o_empty falls on the same edge.
  - A pop at edge k shows the next word after edge k.
- Per-lane update on posedge:
  - On push_ok: wr_ptr += 1.
  - On pop_ok: rd_ptr += 1.
  - count += push_ok - pop_ok; simultaneous push and pop leaves count unchanged.
- Error flags:
  - i_push & ~push_ok sets err[0] (overflow); the write is dropped, o_wen=0, and state is unchanged.
  - i_pop with count==0 sets err[1] (underflow); the state is unchanged.
  - Push and pop together while empty: the push is accepted, the pop is rejected, and err[1] is set.
  - Error flags clear only on rst.
- rst: wr_ptr=0, rd_ptr=0, count=0, err=0. While rst is high: o_wen=0, o_rd_addr=0, o_wr_addr=0, o_empty=all ones, o_full=0, o_count=0.
- i_clr: same pointer/count effect as rst, err is kept. It overrides push/pop in the same cycle: no write, no error set.
- Reset or clear mid-stream discards contents; m2 memory contents are not cleared.
- Outputs o_empty, o_full and o_count are decoded from registered count, with no combinational path from i_push/i_pop.
- Only o_wen and o_rd_addr depend combinationally on the request inputs.

Test Plan:
- Lane 0 push of A0..A3 on 4 consecutive cycles, then pop ×4:
  - o_wr_addr[1:0] = 0,1,2,3.
  - o_full[0]=1 after the 4th push.
  - m2 head = A0,A1,A2,A3.
  - o_empty[0]=1 at the end; o_err=0.
- Lane 3 full, push plus pop in the same cycle:
  - o_wen[3]=1 and count stays 4.
  - The new word appears after 3 further pops.
  - err overflow stays 0.
- Lane 5 full, push only: o_wen[5]=0, count=4, o_err[10]=1 sticky through i_clr, cleared only by rst.
- Lane 7 empty, push plus pop together: count becomes 1, o_err[15]=1, and the head equals the pushed word on the next cycle.
- Wrap: 10 push/pop pairs on lane 1 at steady count 1. The pointers wrap 3→0 and the data order is preserved.
- All 16 lanes at count 2, assert i_clr with i_push=all ones:
  - o_wen=0.
  - The next cycle has o_empty=0xFFFF and o_count=0.
  - The err bits are unchanged.
- Assert rst mid-stream: all outputs take their reset values on the next edge.

Source files
------------

// File: rtl/m2_fifo_ctrl.sv
// Per-lane FIFO pointer controller for the m2 forward buffer: turns push/pop requests into
// m2 write/read addresses and write enables, and tracks occupancy and sticky error flags.
module m2_fifo_ctrl #(
  parameter int unsigned Tn        = 16,
  parameter int unsigned ADDR      = 2,
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic [Tn-1:0]          i_push,
  input  logic [Tn-1:0]          i_pop,
  output logic [ADDR*Tn-1:0]     o_wr_addr,
  output logic [ADDR*Tn-1:0]     o_rd_addr,
  output logic [Tn-1:0]          o_wen,
  output logic [Tn-1:0]          o_empty,
  output logic [Tn-1:0]          o_full,
  output logic [(ADDR+1)*Tn-1:0] o_count,
  output logic [2*Tn-1:0]        o_err
);

  localparam int unsigned CntW = ADDR + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(NUM_WORDS);

  logic [Tn-1:0][ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [Tn-1:0][ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [Tn-1:0][CntW-1:0] count_q, count_d;
  logic [Tn-1:0][1:0]      err_q, err_d;

  logic [Tn-1:0] pop_ok;
  logic [Tn-1:0] push_ok;

  // A push into a full lane only lands when the head leaves in the same cycle.
  always_comb begin
    pop_ok  = '0;
    push_ok = '0;
    for (int i = 0; i < Tn; i++) begin
      pop_ok[i]  = i_pop[i] & (count_q[i] != '0);
      push_ok[i] = i_push[i] & ((count_q[i] != CntFull) | pop_ok[i]);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (i_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      for (int i = 0; i < Tn; i++) begin
        wr_ptr_d[i] = wr_ptr_q[i] + ADDR'(push_ok[i]);
        rd_ptr_d[i] = rd_ptr_q[i] + ADDR'(pop_ok[i]);
        count_d[i]  = count_q[i] + CntW'(push_ok[i]) - CntW'(pop_ok[i]);
        err_d[i][0] = err_q[i][0] | (i_push[i] & ~push_ok[i]);
        err_d[i][1] = err_q[i][1] | (i_pop[i] & ~pop_ok[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // m2 registers the read address, so present the post-pop head address this cycle.
  always_comb begin
    o_wr_addr = '0;
    o_rd_addr = '0;
    o_wen     = '0;
    o_empty   = '1;
    o_full    = '0;
    o_count   = '0;
    for (int i = 0; i < Tn; i++) begin
      o_err[2*i +: 2] = err_q[i];
      if (!rst) begin
        o_wen[i]                = push_ok[i] & ~i_clr;
        o_wr_addr[i*ADDR +: ADDR] = wr_ptr_q[i];
        o_rd_addr[i*ADDR +: ADDR] = rd_ptr_q[i] + ADDR'(pop_ok[i]);
        o_empty[i]              = (count_q[i] == '0);
        o_full[i]               = (count_q[i] == CntFull);
        o_count[i*CntW +: CntW] = count_q[i];
      end
    end
  end

endmodule

// File: tb/tb_m2_fifo_ctrl.sv
// Directed bench for m2_fifo_ctrl with a behavioural m2 (registered read address) attached.
module tb_m2_fifo_ctrl;

  localparam int Tn = 16;

  logic          clk = 1'b0;
  logic          rst, i_clr;
  logic [15:0]   i_push, i_pop;
  logic [31:0]   o_wr_addr, o_rd_addr;
  logic [15:0]   o_wen, o_empty, o_full;
  logic [47:0]   o_count;
  logic [31:0]   o_err;

  int tests = 0;
  int fails = 0;

  logic [7:0] wdata [Tn];
  logic [7:0] mem   [Tn][4];
  logic [1:0] rd_q  [Tn];

  m2_fifo_ctrl #(.Tn(16), .ADDR(2), .NUM_WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (i_clr),
    .i_push    (i_push),
    .i_pop     (i_pop),
    .o_wr_addr (o_wr_addr),
    .o_rd_addr (o_rd_addr),
    .o_wen     (o_wen),
    .o_empty   (o_empty),
    .o_full    (o_full),
    .o_count   (o_count),
    .o_err     (o_err)
  );

  always #5 clk = ~clk;

  // m2 model: write on wen, read address registered, data read from the registered address.
  always @(posedge clk) begin
    for (int i = 0; i < Tn; i++) begin
      if (o_wen[i]) mem[i][o_wr_addr[i*2 +: 2]] <= wdata[i];
      rd_q[i] <= o_rd_addr[i*2 +: 2];
    end
  end

  function automatic logic [7:0] head(int i);
    return mem[i][rd_q[i]];
  endfunction

  function automatic logic [2:0] cnt(int i);
    return o_count[i*3 +: 3];
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; i_clr = 1'b0; i_push = '1; i_pop = '1;
    for (int i = 0; i < Tn; i++) wdata[i] = 8'h00;
    tick(); tick();
    #1;
    chk("rst_wen", o_wen, 0);
    chk("rst_rd_addr", o_rd_addr, 0);
    chk("rst_empty", o_empty, 16'hFFFF);
    chk("rst_full", o_full, 0);
    chk("rst_count", o_count, 0);
    chk("rst_err", o_err, 0);
    rst = 1'b0; i_push = '0; i_pop = '0;
    tick();

    // Lane 0: fill then drain.
    for (int k = 0; k < 4; k++) begin
      i_push[0] = 1'b1; wdata[0] = 8'hA0 + 8'(k);
      #1;
      chk("l0_wr_addr", o_wr_addr[1:0], k);
      chk("l0_wen", o_wen[0], 1);
      tick();
    end
    i_push = '0;
    chk("l0_full", o_full[0], 1);
    chk("l0_count4", cnt(0), 4);
    for (int k = 0; k < 4; k++) begin
      chk("l0_head", head(0), 8'hA0 + 8'(k));
      i_pop[0] = 1'b1;
      tick();
    end
    i_pop = '0;
    chk("l0_empty", o_empty[0], 1);
    chk("l0_err", o_err, 0);

    // Lanes 3 and 5: fill both.
    for (int k = 0; k < 4; k++) begin
      i_push[3] = 1'b1; wdata[3] = 8'hB0 + 8'(k);
      i_push[5] = 1'b1; wdata[5] = 8'hE0 + 8'(k);
      tick();
    end
    chk("l35_full", o_full, 16'h0028);
    // Lane 3 push+pop while full, lane 5 push only while full.
    wdata[3] = 8'hB4; i_pop[3] = 1'b1;
    #1;
    chk("l3_wen_pp", o_wen[3], 1);
    chk("l5_wen_ovf", o_wen[5], 0);
    tick();
    i_push = '0; i_pop = '0;
    chk("l3_count_pp", cnt(3), 4);
    chk("l5_count_ovf", cnt(5), 4);
    chk("l3_no_ovf", o_err[6], 0);
    chk("l5_ovf", o_err[10], 1);
    for (int k = 1; k < 4; k++) begin
      chk("l3_head", head(3), 8'hB0 + 8'(k));
      i_pop[3] = 1'b1;
      tick();
      i_pop = '0;
    end
    chk("l3_new_word", head(3), 8'hB4);
    chk("l3_count1", cnt(3), 1);

    // Clear keeps sticky errors.
    i_clr = 1'b1; tick(); i_clr = 1'b0;
    chk("clr_l5_count", cnt(5), 0);
    chk("clr_err_kept", o_err[10], 1);

    // Lane 7: push and pop together while empty.
    i_push[7] = 1'b1; i_pop[7] = 1'b1; wdata[7] = 8'hC0;
    tick();
    i_push = '0; i_pop = '0;
    chk("l7_count", cnt(7), 1);
    chk("l7_udf", o_err[15], 1);
    chk("l7_no_ovf", o_err[14], 0);
    chk("l7_head", head(7), 8'hC0);
    i_pop[7] = 1'b1; tick(); i_pop = '0;
    chk("l7_empty", o_empty[7], 1);

    // Lane 1: steady count 1, pointers wrap.
    i_push[1] = 1'b1; wdata[1] = 8'hD0; tick();
    for (int k = 0; k < 10; k++) begin
      i_pop[1] = 1'b1; wdata[1] = 8'hD1 + 8'(k);
      #1;
      chk("l1_head", head(1), 8'hD0 + 8'(k));
      chk("l1_wr_addr", o_wr_addr[3:2], (k + 1) % 4);
      chk("l1_rd_addr", o_rd_addr[3:2], (k + 1) % 4);
      tick();
      chk("l1_count", cnt(1), 1);
    end
    i_push = '0; i_pop = '0;
    chk("l1_last", head(1), 8'hDA);

    // All lanes to count 2, then clear with push asserted.
    i_clr = 1'b1; tick(); i_clr = 1'b0;
    i_push = '1; tick(); tick();
    chk("all_count2", o_count, {16{3'd2}});
    i_clr = 1'b1;
    #1;
    chk("clr_wen", o_wen, 0);
    tick();
    i_clr = 1'b0; i_push = '0;
    chk("clr_empty", o_empty, 16'hFFFF);
    chk("clr_count", o_count, 0);
    chk("clr_err", o_err, 32'h0000_8400);

    // Reset mid-stream.
    i_push = '1; tick();
    chk("pre_rst_count", o_count, {16{3'd1}});
    rst = 1'b1; i_pop = '1;
    #1;
    chk("rst_mid_wen", o_wen, 0);
    chk("rst_mid_rd", o_rd_addr, 0);
    chk("rst_mid_wr", o_wr_addr, 0);
    tick();
    rst = 1'b0; i_push = '0; i_pop = '0;
    #1;
    chk("post_rst_err", o_err, 0);
    chk("post_rst_count", o_count, 0);
    chk("post_rst_empty", o_empty, 16'hFFFF);
    chk("post_rst_full", o_full, 0);
    chk("post_rst_wr", o_wr_addr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
